// File: rtl/dptr_seq.sv
// dptr_seq: owner of the 16-bit data pointer (DPH:DPL) and sequencer for every
// access the core makes through it.
//
// Arbitrates SFR-bus byte writes to DPL/DPH against core micro-commands (LOAD16,
// INC, MOVX_RD, MOVX_WR, MOVC_RD). Memory commands run as a req/ack transaction
// toward the external/code memory port. The number of cycles spent waiting for
// mem_ack is bounded, and a request that runs out of time completes with rsp_err.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   sfr_we, sfr_bit_we,     SFR byte write; ignored when sfr_bit_we is set
//   sfr_addr, sfr_wdata
//   cmd_valid, cmd_ready,   command handshake; cmd_ready is high only in IDLE
//   cmd_op, cmd_imm,        opcode, LOAD16 value, MOVC offset, MOVX_WR data
//   cmd_acc, cmd_wdata
//   dph, dpl                current pointer bytes
//   mem_req, mem_we,        memory request, held stable while waiting
//   mem_code, mem_addr,
//   mem_wdata
//   mem_ack, mem_rdata      memory completion and read data
//   rsp_valid, rsp_data,    one-cycle completion pulse, read result, timeout flag
//   rsp_err
module dptr_seq #(
  parameter logic [7:0]  SFR_DPL = 8'h82,
  parameter logic [7:0]  SFR_DPH = 8'h83,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sfr_we,
  input  logic        sfr_bit_we,
  input  logic [7:0]  sfr_addr,
  input  logic [7:0]  sfr_wdata,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_imm,
  input  logic [7:0]  cmd_acc,
  input  logic [7:0]  cmd_wdata,
  output logic [7:0]  dph,
  output logic [7:0]  dpl,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_code,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err
);

  localparam logic [2:0] OpLoad16 = 3'd0;
  localparam logic [2:0] OpInc    = 3'd1;
  localparam logic [2:0] OpMovxRd = 3'd2;
  localparam logic [2:0] OpMovxWr = 3'd3;
  localparam logic [2:0] OpMovcRd = 3'd4;

  // Counter value of the last cycle in which an ack is still accepted.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [7:0]  dph_q, dph_d;
  logic [7:0]  dpl_q, dpl_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_code_q, mem_code_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic [15:0] dptr;
  logic        cmd_accept;

  assign dptr       = {dph_q, dpl_q};
  assign cmd_ready  = (state_q == StIdle);
  assign cmd_accept = cmd_valid && (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    dph_d       = dph_q;
    dpl_d       = dpl_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_code_d  = mem_code_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    // SFR writes land first so that a same-edge LOAD16/INC overrides them below.
    if (sfr_we && !sfr_bit_we) begin
      if (sfr_addr == SFR_DPL) dpl_d = sfr_wdata;
      if (sfr_addr == SFR_DPH) dph_d = sfr_wdata;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          case (cmd_op)
            OpLoad16: begin
              {dph_d, dpl_d} = cmd_imm;
              rsp_valid_d    = 1'b1;
              rsp_err_d      = 1'b0;
            end
            OpInc: begin
              {dph_d, dpl_d} = dptr + 16'd1;
              rsp_valid_d    = 1'b1;
              rsp_err_d      = 1'b0;
            end
            OpMovxRd, OpMovxWr: begin
              // Address comes from the registered pointer, i.e. before any
              // same-edge SFR write.
              mem_addr_d  = dptr;
              mem_we_d    = (cmd_op == OpMovxWr);
              mem_wdata_d = cmd_wdata;
              mem_code_d  = 1'b0;
              mem_req_d   = 1'b1;
              cnt_d       = 8'd0;
              state_d     = StWait;
            end
            OpMovcRd: begin
              mem_addr_d = dptr + {8'h00, cmd_acc};
              mem_we_d   = 1'b0;
              mem_code_d = 1'b1;
              mem_req_d  = 1'b1;
              cnt_d      = 8'd0;
              state_d    = StWait;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b0;
            end
          endcase
        end
      end
      StWait: begin
        // Ack takes priority over a timeout on the same edge.
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          if (!mem_we_q) rsp_data_d = mem_rdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          mem_req_d   = 1'b0;
          rsp_data_d  = 8'hFF;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      dph_q       <= 8'h00;
      dpl_q       <= 8'h00;
      cnt_q       <= 8'h00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_code_q  <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dph_q       <= dph_d;
      dpl_q       <= dpl_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_code_q  <= mem_code_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign dph       = dph_q;
  assign dpl       = dpl_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_code  = mem_code_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dptr_seq.sv
// tb_dptr_seq: directed bench for dptr_seq with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_dptr_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        sfr_we, sfr_bit_we;
  logic [7:0]  sfr_addr, sfr_wdata;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_imm;
  logic [7:0]  cmd_acc, cmd_wdata;
  logic [7:0]  dph, dpl;
  logic        mem_req, mem_we, mem_code;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clock = ~clock;

  dptr_seq #(
    .SFR_DPL (8'h82),
    .SFR_DPH (8'h83),
    .TIMEOUT (4)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .sfr_we     (sfr_we),
    .sfr_bit_we (sfr_bit_we),
    .sfr_addr   (sfr_addr),
    .sfr_wdata  (sfr_wdata),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_imm    (cmd_imm),
    .cmd_acc    (cmd_acc),
    .cmd_wdata  (cmd_wdata),
    .dph        (dph),
    .dpl        (dpl),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_code   (mem_code),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one command for one edge.
  task automatic do_cmd(input logic [2:0] op, input logic [15:0] imm,
                        input logic [7:0] acc, input logic [7:0] wd);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    cmd_acc   = acc;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic sfr_set(input logic [7:0] addr, input logic [7:0] data, input logic bitq);
    sfr_we     = 1'b1;
    sfr_bit_we = bitq;
    sfr_addr   = addr;
    sfr_wdata  = data;
  endtask

  task automatic sfr_clr();
    sfr_we     = 1'b0;
    sfr_bit_we = 1'b0;
  endtask

  // Counts cycles with mem_req high, bounded so a stuck request cannot hang.
  task automatic count_req(output int cnt);
    cnt = 0;
    while (mem_req && cnt < 20) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    int cyc;
    reset     = 1'b0;
    sfr_we    = 1'b0; sfr_bit_we = 1'b0; sfr_addr = 8'h00; sfr_wdata = 8'h00;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_imm = 16'h0; cmd_acc = 8'h0; cmd_wdata = 8'h0;
    mem_ack   = 1'b0; mem_rdata = 8'h00;

    #12;
    check("rst_dptr", {dph, dpl}, 16'h0000);
    check("rst_req", {15'd0, mem_req}, 16'd0);
    check("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check("rst_ready", {15'd0, cmd_ready}, 16'd1);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("ready_after_rst", {15'd0, cmd_ready}, 16'd1);

    // Load, increment, wrap (back-to-back).
    do_cmd(3'd0, 16'hFFFE, 8'h00, 8'h00);
    check("load_dptr", {dph, dpl}, 16'hFFFE);
    check("load_rsp", {14'd0, rsp_valid, rsp_err}, 16'b10);
    do_cmd(3'd1, 16'h0, 8'h00, 8'h00);
    check("inc1_dptr", {dph, dpl}, 16'hFFFF);
    check("inc1_rsp", {14'd0, rsp_valid, rsp_err}, 16'b10);
    do_cmd(3'd1, 16'h0, 8'h00, 8'h00);
    check("inc2_wrap", {dph, dpl}, 16'h0000);
    check("inc2_rsp", {14'd0, rsp_valid, rsp_err}, 16'b10);
    tick();
    check("rsp_one_cycle", {15'd0, rsp_valid}, 16'd0);

    // NOP code responds, pointer untouched.
    do_cmd(3'd6, 16'h1111, 8'h00, 8'h00);
    check("nop_rsp", {15'd0, rsp_valid}, 16'd1);
    check("nop_dptr", {dph, dpl}, 16'h0000);

    // SFR writes.
    sfr_set(8'h82, 8'h34, 1'b0); tick();
    sfr_set(8'h83, 8'h12, 1'b0); tick();
    sfr_clr();
    check("sfr_dptr", {dph, dpl}, 16'h1234);
    sfr_set(8'h83, 8'h99, 1'b1); tick(); sfr_clr();
    check("sfr_bitwe", {dph, dpl}, 16'h1234);
    sfr_set(8'h82, 8'h55, 1'b0);
    do_cmd(3'd0, 16'hAAAA, 8'h00, 8'h00);
    sfr_clr();
    check("sfr_vs_load", {dph, dpl}, 16'hAAAA);

    // MOVX read, ack sampled at the 3rd edge after accept.
    do_cmd(3'd0, 16'h1234, 8'h00, 8'h00);
    do_cmd(3'd2, 16'h0, 8'h00, 8'h00);
    check("movx_addr", mem_addr, 16'h1234);
    check("movx_we_code", {14'd0, mem_we, mem_code}, 16'b00);
    for (int i = 1; i <= 3; i++) begin
      check("movx_req_hi", {15'd0, mem_req}, 16'd1);
      check("movx_ready_lo", {15'd0, cmd_ready}, 16'd0);
      if (i == 2) sfr_set(8'h82, 8'h77, 1'b0);
      if (i == 3) begin
        sfr_clr();
        check("movx_addr_held", mem_addr, 16'h1234);
        check("sfr_in_wait", {8'h00, dpl}, 16'h0077);
        mem_ack = 1'b1; mem_rdata = 8'h5A;
      end
      tick();
    end
    mem_ack = 1'b0;
    check("movx_done_req", {15'd0, mem_req}, 16'd0);
    check("movx_rsp", {14'd0, rsp_valid, rsp_err}, 16'b10);
    check("movx_rdata", {8'h00, rsp_data}, 16'h005A);
    check("movx_ready_back", {15'd0, cmd_ready}, 16'd1);

    // MOVC with address wrap, ack after one cycle.
    do_cmd(3'd0, 16'hFFF0, 8'h00, 8'h00);
    do_cmd(3'd4, 16'h0, 8'h20, 8'h00);
    check("movc_addr", mem_addr, 16'h0010);
    check("movc_we_code", {14'd0, mem_we, mem_code}, 16'b01);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0;
    check("movc_rdata", {7'd0, rsp_valid, rsp_data}, 16'h013C);

    // MOVX write with a same-edge SFR write: access uses the old pointer.
    sfr_set(8'h82, 8'h00, 1'b0);
    do_cmd(3'd3, 16'h0, 8'h00, 8'hC3);
    sfr_clr();
    check("movxw_addr", mem_addr, 16'hFFF0);
    check("movxw_dptr", {dph, dpl}, 16'hFF00);
    check("movxw_we_code", {14'd0, mem_we, mem_code}, 16'b10);
    check("movxw_wdata", {8'h00, mem_wdata}, 16'h00C3);
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    check("movxw_rsp_keep", {7'd0, rsp_valid, rsp_data}, 16'h013C);

    // Timeout with TIMEOUT = 4.
    do_cmd(3'd2, 16'h0, 8'h00, 8'h00);
    count_req(cyc);
    check("to_req_cycles", 16'(cyc), 16'd4);
    check("to_rsp", {6'd0, rsp_valid, rsp_err, rsp_data}, 16'h03FF);
    tick();
    check("to_pulse_end", {15'd0, rsp_valid}, 16'd0);

    // Ack in the 4th cycle wins over the timeout.
    do_cmd(3'd2, 16'h0, 8'h00, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      check("late_req_hi", {15'd0, mem_req}, 16'd1);
      if (i == 4) begin mem_ack = 1'b1; mem_rdata = 8'h81; end
      tick();
    end
    mem_ack = 1'b0;
    check("late_ack_rsp", {6'd0, rsp_valid, rsp_err, rsp_data}, 16'h0281);
    check("late_ack_req", {15'd0, mem_req}, 16'd0);

    // Reset in the middle of a wait.
    do_cmd(3'd0, 16'h4321, 8'h00, 8'h00);
    do_cmd(3'd3, 16'h0, 8'h00, 8'h99);
    tick();
    check("pre_rst_req", {15'd0, mem_req}, 16'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_req", {15'd0, mem_req}, 16'd0);
    check("mid_rst_dptr", {dph, dpl}, 16'h0000);
    check("mid_rst_addr", mem_addr, 16'h0000);
    check("mid_rst_misc", {mem_we, mem_code, rsp_valid, rsp_err, 4'd0, mem_wdata},
          16'h0000);
    check("mid_rst_rdata", {8'h00, rsp_data}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("post_rst_ready", {15'd0, cmd_ready}, 16'd1);
    mem_ack = 1'b1; mem_rdata = 8'h42;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_ignored", {6'd0, rsp_valid, mem_req, rsp_data}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
